// File: rtl/exec_writeback_pkg.sv
// Shared constants for the execute/writeback block and anything that talks to it.
// Holds data/select widths, instruction field widths, op-code values,
// flag bit positions inside the {C, F, Z, N} flag word and the FSM state encoding.
package exec_writeback_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned INSTR_W = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h5;
    localparam logic [OP_W-1:0] OP_MOVI = 4'h6;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h7;
    localparam logic [OP_W-1:0] OP_CMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h9;
    localparam logic [OP_W-1:0] OP_SHR  = 4'hA;

    // Flag word layout: {C, F(overflow), Z, N}
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_writeback.
// Ports: i_op_a/i_op_b latched operands, i_imm8 immediate, i_op op-code;
//        o_result, o_flags {C,F,Z,N}, o_write_en (op writes rd),
//        o_flag_en (op updates the flag register; low for NOPs).
module exec_alu
    import exec_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W
) (
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic [IMM_W-1:0]      i_imm8,
    input  logic [OP_W-1:0]       i_op,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [FLAG_W-1:0]     o_flags,
    output logic                  o_write_en,
    output logic                  o_flag_en
);

    localparam int unsigned DW = DATA_WIDTH;

    logic [DW-1:0] w_imm_sext;
    logic [DW-1:0] w_imm_zext;
    logic [DW-1:0] w_addend;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic          w_c;
    logic          w_f;

    assign w_imm_sext = {{(DW-IMM_W){i_imm8[IMM_W-1]}}, i_imm8};
    assign w_imm_zext = {{(DW-IMM_W){1'b0}}, i_imm8};
    assign w_addend   = (i_op == OP_ADDI) ? w_imm_sext : i_op_b;

    // Extra top bit carries the carry-out (add) or the borrow (subtract)
    assign w_sum  = {1'b0, i_op_a} + {1'b0, w_addend};
    assign w_diff = {1'b0, i_op_a} - {1'b0, i_op_b};

    // Result, carry/overflow and enables per op-code
    always_comb begin
        o_result   = '0;
        w_c        = 1'b0;
        w_f        = 1'b0;
        o_write_en = 1'b1;
        o_flag_en  = 1'b1;
        case (i_op)
            OP_ADD, OP_ADDI: begin
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_f      = (i_op_a[DW-1] == w_addend[DW-1]) && (o_result[DW-1] != i_op_a[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                o_result   = w_diff[DW-1:0];
                w_c        = w_diff[DW];
                w_f        = (i_op_a[DW-1] != i_op_b[DW-1]) && (o_result[DW-1] != i_op_a[DW-1]);
                o_write_en = (i_op == OP_SUB);
            end
            OP_AND:  o_result = i_op_a & i_op_b;
            OP_OR:   o_result = i_op_a | i_op_b;
            OP_XOR:  o_result = i_op_a ^ i_op_b;
            OP_MOV:  o_result = i_op_b;
            OP_MOVI: o_result = w_imm_zext;
            OP_SHL: begin
                o_result = {i_op_a[DW-2:0], 1'b0};
                w_c      = i_op_a[DW-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_op_a[DW-1:1]};
                w_c      = i_op_a[0];
            end
            default: begin
                o_write_en = 1'b0;
                o_flag_en  = 1'b0;
            end
        endcase
    end

    // Flag word assembly; Z/N always follow the result
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_F] = w_f;
        o_flags[FLAG_Z] = (o_result == '0);
        o_flags[FLAG_N] = o_result[DW-1];
    end

endmodule

// File: rtl/exec_writeback.sv
// Four-state execute/writeback engine: IDLE accepts an instruction, READ latches
// the register-file operands, EXEC registers the ALU result and flags, WB drives
// the register-file write and the Done pulse for one cycle.
// Ports: i_clk, i_rst (async, active high); i_instr/i_instr_valid/o_instr_ready
//        instruction handshake; o_select_a/o_select_b read selects with i_a/i_b
//        read data; o_select_input/o_in/o_write_enable write port;
//        o_flags {C,F,Z,N}; o_done retire pulse.
module exec_writeback
    import exec_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned SEL_WIDTH  = SEL_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic                  i_instr_valid,
    output logic                  o_instr_ready,
    output logic [SEL_WIDTH-1:0]  o_select_a,
    output logic [SEL_WIDTH-1:0]  o_select_b,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [SEL_WIDTH-1:0]  o_select_input,
    output logic [DATA_WIDTH-1:0] o_in,
    output logic                  o_write_enable,
    output logic [FLAG_W-1:0]     o_flags,
    output logic                  o_done
);

    state_t                r_state, w_state_next;
    logic [OP_W-1:0]       r_op, w_op_next;
    logic [SEL_WIDTH-1:0]  r_rd, w_rd_next;
    logic [SEL_WIDTH-1:0]  r_rs, w_rs_next;
    logic [IMM_W-1:0]      r_imm8, w_imm8_next;
    logic [DATA_WIDTH-1:0] r_op_a, w_op_a_next;
    logic [DATA_WIDTH-1:0] r_op_b, w_op_b_next;
    logic [FLAG_W-1:0]     r_flags_calc, w_flags_calc_next;
    logic                  r_flag_en, w_flag_en_next;
    logic [FLAG_W-1:0]     r_flags, w_flags_next;
    logic                  r_instr_ready, w_instr_ready_next;
    logic                  r_write_enable, w_write_enable_next;
    logic                  r_done, w_done_next;
    logic [DATA_WIDTH-1:0] r_in, w_in_next;
    logic [SEL_WIDTH-1:0]  r_select_input, w_select_input_next;

    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [FLAG_W-1:0]     w_alu_flags;
    logic                  w_alu_write_en;
    logic                  w_alu_flag_en;

    exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_op_a     (r_op_a),
        .i_op_b     (r_op_b),
        .i_imm8     (r_imm8),
        .i_op       (r_op),
        .o_result   (w_alu_result),
        .o_flags    (w_alu_flags),
        .o_write_en (w_alu_write_en),
        .o_flag_en  (w_alu_flag_en)
    );

    // Next-state and next-output logic; write-port outputs default to zero
    always_comb begin
        w_state_next        = r_state;
        w_op_next           = r_op;
        w_rd_next           = r_rd;
        w_rs_next           = r_rs;
        w_imm8_next         = r_imm8;
        w_op_a_next         = r_op_a;
        w_op_b_next         = r_op_b;
        w_flags_calc_next   = r_flags_calc;
        w_flag_en_next      = r_flag_en;
        w_flags_next        = r_flags;
        w_write_enable_next = 1'b0;
        w_done_next         = 1'b0;
        w_in_next           = '0;
        w_select_input_next = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    w_op_next    = i_instr[15:12];
                    w_rd_next    = SEL_WIDTH'(i_instr[11:8]);
                    w_rs_next    = SEL_WIDTH'(i_instr[7:4]);
                    w_imm8_next  = i_instr[7:0];
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_op_a_next  = i_a;
                w_op_b_next  = i_b;
                w_state_next = ST_EXEC;
            end
            // Write-port outputs are registered here so they are live during WB
            ST_EXEC: begin
                w_flags_calc_next   = w_alu_flags;
                w_flag_en_next      = w_alu_flag_en;
                w_write_enable_next = w_alu_write_en;
                w_done_next         = 1'b1;
                w_in_next           = w_alu_result;
                w_select_input_next = r_rd;
                w_state_next        = ST_WB;
            end
            ST_WB: begin
                if (r_flag_en) begin
                    w_flags_next = r_flags_calc;
                end
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_instr_ready_next = (w_state_next == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_op           <= '0;
            r_rd           <= '0;
            r_rs           <= '0;
            r_imm8         <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_flags_calc   <= '0;
            r_flag_en      <= 1'b0;
            r_flags        <= '0;
            r_instr_ready  <= 1'b1;
            r_write_enable <= 1'b0;
            r_done         <= 1'b0;
            r_in           <= '0;
            r_select_input <= '0;
        end else begin
            r_state        <= w_state_next;
            r_op           <= w_op_next;
            r_rd           <= w_rd_next;
            r_rs           <= w_rs_next;
            r_imm8         <= w_imm8_next;
            r_op_a         <= w_op_a_next;
            r_op_b         <= w_op_b_next;
            r_flags_calc   <= w_flags_calc_next;
            r_flag_en      <= w_flag_en_next;
            r_flags        <= w_flags_next;
            r_instr_ready  <= w_instr_ready_next;
            r_write_enable <= w_write_enable_next;
            r_done         <= w_done_next;
            r_in           <= w_in_next;
            r_select_input <= w_select_input_next;
        end
    end

    assign o_instr_ready  = r_instr_ready;
    assign o_select_a     = r_rd;
    assign o_select_b     = r_rs;
    assign o_select_input = r_select_input;
    assign o_in           = r_in;
    assign o_write_enable = r_write_enable;
    assign o_flags        = r_flags;
    assign o_done         = r_done;

endmodule

// File: tb/tb_exec_writeback.sv
// Directed bench for exec_writeback attached to a 16x16 register file.
module tb_exec_writeback;
    import exec_writeback_pkg::*;

    typedef struct packed {
        logic [31:0]      t;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               rf_rst;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [SEL_W-1:0]   sel_a, sel_b, sel_in;
    logic [DATA_W-1:0]  a_data, b_data, wdata;
    logic               we, done;
    logic [FLAG_W-1:0]  flags;

    logic               poke_en;
    logic [SEL_W-1:0]   poke_sel;
    logic [DATA_W-1:0]  poke_data;

    logic [DATA_W-1:0]  rf [16];
    logic [31:0]        cyc = 0;
    int                 n_cmp = 0;
    int                 n_fail = 0;
    exp_t               sb[$];

    always #5 clk = ~clk;

    exec_writeback dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_instr        (instr),
        .i_instr_valid  (instr_valid),
        .o_instr_ready  (instr_ready),
        .o_select_a     (sel_a),
        .o_select_b     (sel_b),
        .i_a            (a_data),
        .i_b            (b_data),
        .o_select_input (sel_in),
        .o_in           (wdata),
        .o_write_enable (we),
        .o_flags        (flags),
        .o_done         (done)
    );

    // Register file: resets once at start, DUT write wins over bench preload
    always @(posedge clk or posedge rf_rst) begin
        if (rf_rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (we) begin
            rf[sel_in] <= wdata;
        end else if (poke_en) begin
            rf[poke_sel] <= poke_data;
        end
    end
    assign a_data = rf[sel_a];
    assign b_data = rf[sel_b];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every Done pops one expected write
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (done) begin
                chk("done_has_expectation", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.t + 3);
                    chk("write_enable", 32'(we), 32'(e.we));
                    if (e.we) begin
                        chk("write_select", 32'(sel_in), 32'(e.sel));
                        chk("write_data", 32'(wdata), 32'(e.data));
                    end
                end
            end else begin
                chk("quiet_we_in", {15'b0, we, wdata}, 0);
            end
        end
    end

    task automatic send(input logic [15:0] ins, input logic exp_we, input logic [3:0] exp_sel,
                        input logic [15:0] exp_data, output logic [31:0] t);
        int k = 0;
        instr       = ins;
        instr_valid = 1'b1;
        while (!instr_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", 32'(k < 40), 1);
        @(posedge clk);
        t = cyc;
        sb.push_back('{t: t, we: exp_we, sel: exp_sel, data: exp_data});
        #1;
    endtask

    task automatic retire();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("retire_in_time", 32'(k < 40), 1);
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] ins, input logic exp_we, input logic [3:0] exp_sel,
                       input logic [15:0] exp_data);
        logic [31:0] t;
        send(ins, exp_we, exp_sel, exp_data, t);
        instr_valid = 1'b0;
        retire();
    endtask

    task automatic poke(input logic [3:0] s, input logic [15:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_sel  = s;
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] t0, t1, t2, t3, tr;
        rst = 1'b1; rf_rst = 1'b1; instr = '0; instr_valid = 1'b0;
        poke_en = 1'b0; poke_sel = '0; poke_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_we", 32'(we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in", 32'(wdata), 0);
        chk("rst_sel_in", 32'(sel_in), 0);
        chk("rst_sel_a", 32'(sel_a), 0);
        chk("rst_sel_b", 32'(sel_b), 0);
        chk("rst_flags", 32'(flags), 0);
        rf_rst = 1'b0;
        rst    = 1'b0;

        // MOVI / MOVI / ADD
        run(16'h6105, 1'b1, 4'd1, 16'h0005);
        chk("r1_movi", 32'(rf[1]), 32'h5);
        run(16'h6203, 1'b1, 4'd2, 16'h0003);
        run(16'h0120, 1'b1, 4'd1, 16'h0008);
        chk("r1_add", 32'(rf[1]), 32'h8);
        chk("flags_add", 32'(flags), 32'h0);
        chk("sel_a_latched", 32'(sel_a), 1);
        chk("sel_b_latched", 32'(sel_b), 2);

        // Carry/zero then CMP
        poke(4'd1, 16'hFFFF);
        poke(4'd2, 16'h0001);
        run(16'h0120, 1'b1, 4'd1, 16'h0000);
        chk("r1_add_wrap", 32'(rf[1]), 0);
        chk("flags_add_cz", 32'(flags), 32'hA);
        run(16'h8210, 1'b0, 4'd0, 16'h0000);
        chk("flags_cmp", 32'(flags), 32'h0);
        chk("r2_after_cmp", 32'(rf[2]), 1);

        // ADDI overflow both directions
        poke(4'd3, 16'h7FFF);
        run(16'h7301, 1'b1, 4'd3, 16'h8000);
        chk("flags_addi_pos", 32'(flags), 32'h5);
        run(16'h73FF, 1'b1, 4'd3, 16'h7FFF);
        chk("r3_addi_neg", 32'(rf[3]), 32'h7FFF);
        chk("flags_addi_neg", 32'(flags), 32'hC);

        // Shifts
        poke(4'd10, 16'h8001);
        run(16'h9A00, 1'b1, 4'd10, 16'h0002);
        chk("flags_shl", 32'(flags), 32'h8);
        run(16'hAA00, 1'b1, 4'd10, 16'h0001);
        chk("flags_shr", 32'(flags), 32'h0);
        run(16'hAA00, 1'b1, 4'd10, 16'h0000);
        chk("flags_shr_out", 32'(flags), 32'hA);

        // Logic, MOV, SUB with borrow, MOVI zero-extension
        poke(4'd11, 16'h00F0);
        poke(4'd12, 16'h0F0F);
        run(16'h2BC0, 1'b1, 4'd11, 16'h0000);
        chk("flags_and", 32'(flags), 32'h2);
        run(16'h3CB0, 1'b1, 4'd12, 16'h0F0F);
        run(16'h4C30, 1'b1, 4'd12, 16'h70F0);
        run(16'h5B30, 1'b1, 4'd11, 16'h7FFF);
        chk("flags_mov", 32'(flags), 32'h0);
        run(16'h1230, 1'b1, 4'd2, 16'h8002);
        chk("flags_sub_borrow", 32'(flags), 32'h9);
        run(16'h6D80, 1'b1, 4'd13, 16'h0080);
        chk("r13_movi_zext", 32'(rf[13]), 32'h80);

        // Back-to-back with valid held high
        send(16'h6611, 1'b1, 4'd6, 16'h0011, t0);
        send(16'h6722, 1'b1, 4'd7, 16'h0022, t1);
        send(16'h6833, 1'b1, 4'd8, 16'h0033, t2);
        send(16'h6944, 1'b1, 4'd9, 16'h0044, t3);
        instr_valid = 1'b0;
        retire();
        chk("spacing_1", t1 - t0, 4);
        chk("spacing_2", t2 - t1, 4);
        chk("spacing_3", t3 - t2, 4);
        chk("r6_stream", 32'(rf[6]), 32'h11);
        chk("r9_stream", 32'(rf[9]), 32'h44);

        // Reset during EXEC aborts the instruction
        send(16'h64AA, 1'b1, 4'd4, 16'h00AA, t0);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_ready", 32'(instr_ready), 1);
        chk("abort_we", 32'(we), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_in", 32'(wdata), 0);
        chk("abort_sel_a", 32'(sel_a), 0);
        chk("abort_flags", 32'(flags), 0);
        repeat (2) @(negedge clk);
        chk("r4_untouched", 32'(rf[4]), 0);
        rst = 1'b0;
        tr  = cyc;

        // First edge after reset accepts; NOP leaves registers and flags alone
        send(16'hF5AB, 1'b0, 4'd0, 16'h0000, t0);
        instr_valid = 1'b0;
        retire();
        chk("first_edge_accept", t0, tr);
        chk("r4_still_zero", 32'(rf[4]), 0);
        poke(4'd5, 16'h1234);
        run(16'h1550, 1'b1, 4'd5, 16'h0000);
        chk("r5_sub_self", 32'(rf[5]), 0);
        chk("flags_sub_self", 32'(flags), 32'h2);
        run(16'hB000, 1'b0, 4'd0, 16'h0000);
        chk("flags_nop_keep", 32'(flags), 32'h2);
        chk("r5_after_nop", 32'(rf[5]), 0);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_writeback.md
EXEC_WRITEBACK -- requirements
Module: exec_writeback

Interface
REQ-001 Parameter DATA_WIDTH, 16: register/data width.
REQ-002 Parameter SEL_WIDTH, 4: register-select width (16 registers).
REQ-003 Clock  in  1  single clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm8.
REQ-006 InstrValid  in  1  Instr is valid this cycle.
REQ-007 InstrReady  out  1  block can accept Instr; a transfer occurs when InstrValid and InstrReady are both high at a rising edge.
REQ-008 SelectA  out  4  register-file read select A; always equals the latched rd.
REQ-009 SelectB  out  4  register-file read select B; always equals the latched rs.
REQ-010 A, B  in  16 each  register-file read data, combinational from SelectA/SelectB.
REQ-011 SelectInput  out  4  register-file write select.
REQ-012 In  out  16  register-file write data.
REQ-013 WriteEnable  out  1  register-file write strobe.
REQ-014 Flags  out  4  {C, F(overflow), Z, N}, registered.
REQ-015 Done  out  1  one-cycle pulse when an instruction retires.

Function
REQ-016 FSM states: IDLE, READ, EXEC, WB; InstrReady=1 only in IDLE.
REQ-017 IDLE: on transfer, latch Instr and go to READ; otherwise stay.
REQ-018 READ: latch A into opA and B into opB at the rising edge, then go to EXEC.
REQ-019 EXEC: register the result and the next flag values, then go to WB.
REQ-020 WB: drive WriteEnable=1 (only for writing ops), SelectInput=rd, In=result; update Flags; assert Done; then go to IDLE.
REQ-021 Timing: with the transfer at edge N, the write lands at edge N+3, and the earliest next transfer is at edge N+4.
REQ-022 Writing ops: 0 ADD opA+opB; 1 SUB opA-opB; 2 AND; 3 OR; 4 XOR; 5 MOV opB; 6 MOVI zero-extended imm8; 7 ADDI opA+sign-extended imm8; 9 SHL opA<<1; A SHR opA>>1 (logical).
REQ-023 Op 8 CMP computes opA-opB, updates Flags only, and keeps WriteEnable=0.
REQ-024 Ops B-F are NOPs: no write, no flag change, Done still pulses.
REQ-025 Arithmetic is modulo 2^16.
REQ-026 C is the carry-out for ADD/ADDI and the borrow (opA<opB unsigned) for SUB/CMP; the shifted-out bit for SHL/SHR.
REQ-027 F is the signed overflow for ADD/ADDI/SUB/CMP and is cleared for all other ops.
REQ-028 Z is set when result==0; N is result[15]; logic ops and MOV/MOVI update Z/N and clear C/F.
REQ-029 rd==rs is legal; reading and writing the same register yields the correct result because the write lands after the operands are latched.
REQ-030 WriteEnable, Done and In are zero in every non-WB cycle.

Reset
REQ-031 Reset forces state IDLE, InstrReady=1, and WriteEnable=0, Done=0, In=0, SelectInput=0, SelectA=0, SelectB=0, Flags=0, and clears all latched operands.
REQ-032 Reset asserted mid-instruction (READ/EXEC/WB) aborts it: no write occurs and no Done pulse is issued.
REQ-033 After reset deasserts, an instruction may be accepted on the first rising edge.

Structure
REQ-034 A shared package holds the op-code constants, flag bit indices and FSM state encoding; the register-file block imports the same width constants.
REQ-035 One sub-module, exec_alu: combinational (opA, opB, imm8, op) -> (result, flags, write_en); the FSM and registers live in exec_writeback.

Verification
REQ-036 Connect the block to a 16x16 register file that resets to 0. Run MOVI r1,0x05 then MOVI r2,0x03 then ADD r1,r2 -> r1=0x0008, Flags=0000, WriteEnable high exactly one cycle per instruction at edge N+3.
REQ-037 With r1=0xFFFF and r2=0x0001, run ADD r1,r2 -> r1=0x0000 with C=1, Z=1; then CMP r2,r1 -> no write, C=0, Z=0.
REQ-038 With r3=0x7FFF, run ADDI r3,0x01 -> r3=0x8000 with F=1, N=1; then ADDI r3,0xFF -> r3=0x7FFF with F=1.
REQ-039 Hold InstrValid high continuously -> InstrReady=1 once every 4 cycles, one Done per instruction, and no instruction lost or duplicated.
REQ-040 Assert Reset during EXEC of MOVI r4,0xAA -> r4 stays 0, no Done, all outputs at reset values.
REQ-041 Run op 0xF and SUB r5,r5 with r5=0x1234 -> NOP: no write; SUB: r5=0x0000 with Z=1.
